esl_stream_decoder: RTL and testbench

Downstream stage of the ESL processing element: consumes an ESL bitstream pair (x, y) and converts it back to binary by counting ones in each stream over a fixed window of 2^BIN_LEN enabled cycles. Results are held in an output register behind a valid/ready handshake until the consumer accepts them. The block sits at the end of a PE chain and feeds binary counts to the readout or next-layer logic.

---
 rtl/esl_stream_decoder.sv | 124 ++++++++++++
 tb/tb_esl_stream_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/esl_stream_decoder.sv
// esl_stream_decoder
//   Converts an ESL bitstream pair (x, y) back to binary by counting ones on
//   each stream over a window of 2^BIN_LEN enabled cycles. The result is held
//   behind a valid/ready handshake until the consumer takes it.
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   enable     in   stream-advance qualifier; enable=0 cycles are not samples
//   start      in   single-cycle request to begin a new window
//   in_x       in   ESL x stream bit
//   in_y       in   ESL y stream bit
//   busy       out  window being counted
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   count_x    out  ones on in_x in the last completed window (0..N)
//   count_y    out  ones on in_y in the last completed window (0..N)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; last result still visible on count_x/y
// COUNT  | accumulating ones on each enabled cycle
// HOLD   | result valid, waiting for out_ready
module esl_stream_decoder #(
  parameter int BIN_LEN = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               in_x,
  input  logic               in_y,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIN_LEN:0]   count_x,
  output logic [BIN_LEN:0]   count_y
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [BIN_LEN-1:0] CNT_ONE = {{(BIN_LEN-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [BIN_LEN-1:0] sample_cnt;
  logic [BIN_LEN:0]   acc_x;
  logic [BIN_LEN:0]   acc_y;
  logic [BIN_LEN:0]   bit_x;
  logic [BIN_LEN:0]   bit_y;

  logic sample;
  logic last_sample;
  logic accept;
  logic launch;

  assign bit_x = {{BIN_LEN{1'b0}}, in_x};
  assign bit_y = {{BIN_LEN{1'b0}}, in_y};

  assign sample      = (state == ST_COUNT) && enable;
  // Terminal count: the sample counter is about to wrap, so this is sample N.
  assign last_sample = sample && (sample_cnt == '1);
  assign accept      = (state == ST_HOLD) && out_ready;
  // A new window opens from IDLE, or straight out of HOLD on the accept edge.
  assign launch      = start && ((state == ST_IDLE) || accept);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (last_sample) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept) state_nxt = start ? ST_COUNT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
    end else if (launch) begin
      sample_cnt <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
    end else if (sample) begin
      sample_cnt <= sample_cnt + CNT_ONE;
      acc_x      <= acc_x + bit_x;
      acc_y      <= acc_y + bit_y;
    end
  end

  // The final bit is added here directly because the accumulator only sees
  // it on the same edge; a full window of ones lands exactly on N.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_x <= '0;
      count_y <= '0;
    end else if (last_sample) begin
      count_x <= acc_x + bit_x;
      count_y <= acc_y + bit_y;
    end
  end

  assign busy      = (state == ST_COUNT);
  assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_esl_stream_decoder.sv
module tb_esl_stream_decoder;

  localparam int BIN_LEN = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic in_x = 1'b0;
  logic in_y = 1'b0;
  logic out_ready = 1'b0;
  logic busy;
  logic out_valid;
  logic [BIN_LEN:0] count_x;
  logic [BIN_LEN:0] count_y;

  int n_chk = 0;
  int n_bad = 0;

  esl_stream_decoder #(.BIN_LEN(BIN_LEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .in_x      (in_x),
    .in_y      (in_y),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_x   (count_x),
    .count_y   (count_y)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the start cycle; the edge ending it moves the DUT to COUNT.
  task automatic issue_start();
    start = 1'b1;
    enable = 1'b1;
    in_x = 1'b1;
    in_y = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1 of a window; returns the cycle in which out_valid is
  // first seen high. Modes:
  //   0 x=1 y=0          1 x=1,0,1,0.. y=1      2 enable low every 4th cycle, ones
  //   3 same stalls, stall bits 1, sampled bits 0   4 all zero   5 ones + start pulse
  task automatic count_window(input int mode, input int prev_x, output int lat);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 2000) begin
      enable = 1'b1;
      in_x = 1'b0;
      in_y = 1'b0;
      start = 1'b0;
      case (mode)
        0: in_x = 1'b1;
        1: begin in_x = (cyc % 2 == 1); in_y = 1'b1; end
        2: begin enable = (cyc % 4 != 0); in_x = 1'b1; in_y = 1'b1; end
        3: begin enable = (cyc % 4 != 0); in_x = !enable; in_y = !enable; end
        5: begin in_x = 1'b1; in_y = 1'b1; start = (cyc == 50); end
        default: ;
      endcase
      if (cyc == 100) chk("no_running_sum", 32'(count_x), prev_x);
      tick();
      cyc++;
    end
    enable = 1'b0;
    start = 1'b0;
    in_x = 1'b0;
    in_y = 1'b0;
    lat = cyc;
    if (!out_valid) chk("window_timeout", 32'(out_valid), 1);
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 0);
    chk("idle_after_accept", 32'(busy), 0);
  endtask

  initial begin
    int lat;
    logic stable;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cx", 32'(count_x), 0);
    chk("rst_cy", 32'(count_y), 0);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;      // no effect outside HOLD
    tick();
    out_ready = 1'b0;
    chk("ready_idle_valid", 32'(out_valid), 0);

    // Window 1: x all ones, y all zeros
    issue_start();
    chk("busy_cycle1", 32'(busy), 1);
    count_window(0, 0, lat);
    chk("w1_latency", lat, 257);
    chk("w1_cx", 32'(count_x), 256);
    chk("w1_cy", 32'(count_y), 0);
    chk("w1_busy", 32'(busy), 0);
    accept_result();

    // Window 2: alternating x, y all ones; hold with out_ready low
    issue_start();
    count_window(1, 256, lat);
    chk("w2_latency", lat, 257);
    chk("w2_cx", 32'(count_x), 128);
    chk("w2_cy", 32'(count_y), 256);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_x = (i % 3 == 0);
      in_y = (i % 2 == 0);
      enable = (i % 5 != 0);
      tick();
      if (!out_valid || count_x != 9'd128 || count_y != 9'd256) stable = 1'b0;
    end
    enable = 1'b0;
    chk("w2_hold_stable", 32'(stable), 1);
    accept_result();
    chk("w2_cx_kept_idle", 32'(count_x), 128);

    // Reset in the middle of a window (cycle 100)
    issue_start();
    for (int c = 1; c < 100; c++) begin
      enable = 1'b1;
      in_x = 1'b1;
      in_y = 1'b1;
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_cx", 32'(count_x), 0);
    chk("async_rst_cy", 32'(count_y), 0);
    tick();
    tick();
    reset = 1'b0;
    enable = 1'b0;
    tick();
    issue_start();
    count_window(2, 0, lat);
    chk("stall_latency", lat, 342);
    chk("stall_cx", 32'(count_x), 256);
    chk("stall_cy", 32'(count_y), 256);

    // Back-to-back: start together with out_ready in HOLD
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid", 32'(out_valid), 0);
    chk("b2b_cx_kept", 32'(count_x), 256);
    count_window(4, 256, lat);
    chk("b2b_latency", lat, 257);
    chk("b2b_cx", 32'(count_x), 0);
    chk("b2b_cy", 32'(count_y), 0);
    accept_result();

    // Stall cycles carry ones that must not be counted
    issue_start();
    count_window(3, 0, lat);
    chk("stallbits_latency", lat, 342);
    chk("stallbits_cx", 32'(count_x), 0);
    chk("stallbits_cy", 32'(count_y), 0);
    accept_result();

    // start pulsed during COUNT and during HOLD without out_ready
    issue_start();
    count_window(5, 0, lat);
    chk("restart_latency", lat, 257);
    chk("restart_cx", 32'(count_x), 256);
    chk("restart_cy", 32'(count_y), 256);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_start_valid", 32'(out_valid), 1);
    chk("hold_start_busy", 32'(busy), 0);
    chk("hold_start_cx", 32'(count_x), 256);
    accept_result();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
